axi3_sram_slave: RTL and testbench
==================================

Name: axi3_sram_slave

Overview:
- AXI3 slave/responder backed by an internal word-addressed SRAM array; the memory-side counterpart of the core's AXI bridge master.
- Used as the simulation/SoC memory model behind core_top, and as a standalone bench target for the bridge and cache refill/writeback paths.
- Read and write channels have independent FSMs, each with one outstanding transaction.

Parameters:
- ADDR_BITS, 16, byte-address bits decoded; array depth = 2^(ADDR_BITS-2) words.
- BASE_ADDR, 32'h1c000000, base of the decoded window; addresses outside [BASE, BASE+2^ADDR_BITS) get DECERR.
- READ_LAT, 1, cycles from AR handshake edge to first rvalid; legal range 1..15.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- arid  input  4  read ID.
- araddr  input  32  read start byte address.
- arlen  input  8  beats-1; values >15 are clipped to 15.
- arsize  input  3  bytes per beat = 1<<arsize; >2 gives SLVERR.
- arburst  input  2  00 FIXED, 01 INCR, others SLVERR.
- arvalid  input  1  AR valid.
- arready  output  1  AR ready.
- rid  output  4  echoes the captured arid.
- rdata  output  32  full-word read data.
- rresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rlast  output  1  final beat.
- rvalid  output  1  R valid.
- rready  input  1  R ready.
- awid  input  4  write ID.
- awaddr  input  32  write start address.
- awlen  input  8  beats-1; clipped as for arlen.
- awsize  input  3  as arsize.
- awburst  input  2  as arburst.
- awvalid  input  1  AW valid.
- awready  output  1  AW ready.
- wid  input  4  write data ID.
- wdata  input  32  write data.
- wstrb  input  4  byte enables.
- wlast  input  1  final write beat.
- wvalid  input  1  W valid.
- wready  output  1  W ready.
- bid  output  4  echoes the captured awid.
- bresp  output  2  write response, encoded as rresp.
- bvalid  output  1  B valid.
- bready  input  1  B ready.
- The lock, cache and prot sidebands are not ported.

Behaviour:

Reset and output timing:
- All outputs are registered or decoded from the state register only; there is no combinational input-to-output path.
- Reset values: arready=awready=wready=rvalid=rlast=bvalid=0; rid=bid=0; rdata=0; rresp=bresp=0.
- arready and awready go to 1 on the first clock after aresetn deasserts.
- The SRAM array is never reset. Reset asserted mid-burst aborts both FSMs to idle; array contents are retained, including beats already written.

Read FSM (R_IDLE -> R_WAIT -> R_DATA -> R_IDLE):
- R_IDLE: arready=1. On arvalid&&arready, capture id, addr, len, size and burst, and compute the error flags.
- R_WAIT: lasts READ_LAT-1 cycles (0 when READ_LAT=1). rdata is registered from mem[addr[ADDR_BITS-1:2]]. First rvalid is asserted exactly READ_LAT cycles after the AR handshake edge.
- R_DATA: rvalid is held with stable rid, rdata, rresp and rlast until rready.
- On each handshake: INCR advances addr by 1<<size; FIXED keeps addr.
- Next beat is valid on the following cycle, giving 1 beat/cycle with rready held high.
- rlast=1 when beat count equals len. The handshake on that beat returns to R_IDLE with arready=1 on the next cycle.
- Error reads: DECERR returns rdata=0; SLVERR returns array data. All len+1 beats are always returned with the same resp.

Write FSM (W_IDLE -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: awready=1. Capture on handshake, same as the read side.
- W_DATA: wready=1. Each wvalid beat writes the wstrb-selected bytes at the current word on the handshake edge. No write occurs on DECERR, SLVERR, or when wid != captured awid.
- Beat count, not wlast, ends the burst. bresp becomes SLVERR if wlast disagrees with the count, if wid mismatches, or for a bad size/burst.
- W_RESP: bvalid=1 until bready, then W_IDLE. The AW channel is not accepted while the write FSM is busy.

Concurrency and boundaries:
- Simultaneous read and write to the same word in the same cycle: the read returns old data, and the write is visible from the next cycle.
- Address arithmetic is modulo 2^ADDR_BITS within the window. An INCR burst crossing the top of the window wraps to BASE_ADDR; this is defined behaviour with no error.
- The narrow-size byte lane is chosen by the master via wstrb. The slave always returns the full word.

Test Plan:
1. Reset, then AW 0x1c000100 len=3 INCR with 4 beats of wstrb=F, data 11,22,33,44 -> bresp=00, bid=awid. Then AR at the same address, len=3, READ_LAT=1 -> rvalid 1 cycle after AR; data 11,22,33,44 on consecutive cycles; rlast only on beat 4.
2. Write wstrb=4'b0010 with wdata=0xAABBCCDD over stored 0x11223344 -> readback 0x1122CC44.
3. AR 0x00000000 len=1 -> 2 beats, rresp=11, rdata=0. Any write to the same address -> bresp=11 and memory unchanged.
4. rready toggling 1,0,0,1 during a len=2 burst -> rdata/rlast stay stable while stalled; exactly 3 beats delivered. With READ_LAT=4, first rvalid is exactly 4 cycles after the AR handshake.
5. Read and write to the same word in the same cycle -> old data is returned; a subsequent read returns the new data.
6. aresetn pulsed low mid write burst after beat 2 of 4 -> bvalid=0; awready=1 the first cycle after release; beats 1-2 persist and beats 3-4 are unwritten.

Source files
------------

// File: rtl/axi3_sram_slave_if.sv
// axi3_sram_slave_if: AXI3 read/write channel bundle between a master and the SRAM slave
interface axi3_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi3_sram_slave.sv
// axi3_sram_slave: AXI3 responder over a word-addressed SRAM with independent single-outstanding read and write FSMs
module axi3_sram_slave #(
    parameter int          ADDR_BITS = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter int          READ_LAT  = 1
) (
    input logic              aclk,
    input logic              aresetn,
    axi3_sram_slave_if.slave bus
);
    localparam int         DEPTH     = 1 << (ADDR_BITS - 2);
    localparam logic [3:0] WAIT_LAST = 4'(READ_LAT - 2);

    typedef enum logic [1:0] {R_RST, R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t             r_state, r_next;
    logic [31:0]          ar_off;
    logic                 ar_dec, ar_slv, ar_hs, r_hs, r_last, r_load, ld_dec;
    logic [ADDR_BITS-1:0] r_addr, r_addr_inc, ld_addr;
    logic [3:0]           r_len, r_beat, r_wait, r_id;
    logic [2:0]           r_size;
    logic                 r_fixed, r_dec;
    logic [1:0]           r_resp;
    logic [31:0]          r_data;

    w_state_t             w_state, w_next;
    logic [31:0]          aw_off;
    logic                 aw_dec, aw_slv, aw_hs, w_hs, w_last_beat, beat_bad, w_en;
    logic [ADDR_BITS-1:0] w_addr, w_addr_inc;
    logic [3:0]           w_len, w_beat, w_id, b_id;
    logic [2:0]           w_size;
    logic                 w_fixed, w_dec, w_slv, w_bad;
    logic [1:0]           b_resp;

    assign ar_off     = bus.araddr - BASE_ADDR;
    assign ar_dec     = (ar_off >> ADDR_BITS) != '0;
    assign ar_slv     = bus.arsize > 3'd2 || bus.arburst[1];
    assign ar_hs      = bus.arvalid && r_state == R_IDLE;
    assign r_hs       = bus.rready && r_state == R_DATA;
    assign r_last     = r_state == R_DATA && r_beat == r_len;
    assign r_addr_inc = r_fixed ? r_addr : r_addr + (ADDR_BITS'(1) << r_size);

    assign bus.arready = r_state == R_IDLE;
    assign bus.rvalid  = r_state == R_DATA;
    assign bus.rlast   = r_last;
    assign bus.rid     = r_id;
    assign bus.rresp   = r_resp;
    assign bus.rdata   = r_data;

    // Read next state; rdata is fetched on the edge that makes each beat valid
    always_comb begin
        r_next  = r_state;
        r_load  = 1'b0;
        ld_addr = r_addr_inc;
        ld_dec  = r_dec;
        case (r_state)
            R_RST:  r_next = R_IDLE;
            R_IDLE: if (ar_hs) begin
                r_next  = READ_LAT == 1 ? R_DATA : R_WAIT;
                r_load  = READ_LAT == 1;
                ld_addr = ar_off[ADDR_BITS-1:0];
                ld_dec  = ar_dec;
            end
            R_WAIT: if (r_wait == WAIT_LAST) begin
                r_next  = R_DATA;
                r_load  = 1'b1;
                ld_addr = r_addr;
            end
            R_DATA: if (r_hs) begin
                r_next = r_last ? R_IDLE : R_DATA;
                r_load = !r_last;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read state register; reset parks in R_RST so arready rises one clock after release
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) r_state <= R_RST;
        else r_state <= r_next;

    // Read burst context captured at AR and advanced on every R handshake
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_size  <= '0;
            r_fixed <= 1'b0;
            r_dec   <= 1'b0;
            r_id    <= '0;
            r_resp  <= '0;
        end else begin
            if (ar_hs) begin
                r_addr  <= ar_off[ADDR_BITS-1:0];
                r_len   <= bus.arlen > 8'd15 ? 4'd15 : bus.arlen[3:0];
                r_beat  <= '0;
                r_wait  <= '0;
                r_size  <= bus.arsize;
                r_fixed <= bus.arburst == 2'b00;
                r_dec   <= ar_dec;
                r_id    <= bus.arid;
                r_resp  <= ar_dec ? 2'b11 : ar_slv ? 2'b10 : 2'b00;
            end
            if (r_state == R_WAIT) r_wait <= r_wait + 4'd1;
            if (r_hs) begin
                r_addr <= r_addr_inc;
                r_beat <= r_beat + 4'd1;
            end
        end

    // Read data register; out-of-window beats return zero instead of aliased array data
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) r_data <= '0;
        else if (r_load) r_data <= ld_dec ? '0 : mem[ld_addr[ADDR_BITS-1:2]];

    assign aw_off      = bus.awaddr - BASE_ADDR;
    assign aw_dec      = (aw_off >> ADDR_BITS) != '0;
    assign aw_slv      = bus.awsize > 3'd2 || bus.awburst[1];
    assign aw_hs       = bus.awvalid && w_state == W_IDLE;
    assign w_hs        = bus.wvalid && w_state == W_DATA;
    assign w_last_beat = w_beat == w_len;
    assign beat_bad    = bus.wid != w_id || bus.wlast != w_last_beat;
    assign w_en        = w_hs && !w_dec && !w_slv && bus.wid == w_id;
    assign w_addr_inc  = w_fixed ? w_addr : w_addr + (ADDR_BITS'(1) << w_size);

    assign bus.awready = w_state == W_IDLE;
    assign bus.wready  = w_state == W_DATA;
    assign bus.bvalid  = w_state == W_RESP;
    assign bus.bid     = b_id;
    assign bus.bresp   = b_resp;

    // Write next state; the beat count, not wlast, closes the data phase
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_RST:  w_next = W_IDLE;
            W_IDLE: w_next = aw_hs ? W_DATA : W_IDLE;
            W_DATA: w_next = w_hs && w_last_beat ? W_RESP : W_DATA;
            W_RESP: w_next = bus.bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
    end

    // Write state register; reset aborts any burst in flight
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) w_state <= W_RST;
        else w_state <= w_next;

    // Write burst context; protocol slips accumulate into the final bresp
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_id    <= '0;
            w_size  <= '0;
            w_fixed <= 1'b0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
            w_bad   <= 1'b0;
            b_id    <= '0;
            b_resp  <= '0;
        end else begin
            if (aw_hs) begin
                w_addr  <= aw_off[ADDR_BITS-1:0];
                w_len   <= bus.awlen > 8'd15 ? 4'd15 : bus.awlen[3:0];
                w_beat  <= '0;
                w_id    <= bus.awid;
                w_size  <= bus.awsize;
                w_fixed <= bus.awburst == 2'b00;
                w_dec   <= aw_dec;
                w_slv   <= aw_slv;
                w_bad   <= 1'b0;
                b_id    <= bus.awid;
            end
            if (w_hs) begin
                w_addr <= w_addr_inc;
                w_beat <= w_beat + 4'd1;
                w_bad  <= w_bad || beat_bad;
                if (w_last_beat) b_resp <= w_dec ? 2'b11 : (w_slv || w_bad || beat_bad) ? 2'b10 : 2'b00;
            end
        end

    // Byte-lane SRAM writes; the array is not reset so contents survive aresetn
    always_ff @(posedge aclk)
        for (int b = 0; b < 4; b++)
            if (w_en && bus.wstrb[b]) mem[w_addr[ADDR_BITS-1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
endmodule

// File: tb/tb_axi3_sram_slave.sv
// tb_axi3_sram_slave: scoreboard bench for the AXI3 SRAM slave at read latency 1 and 4
module tb_axi3_sram_slave;
    localparam logic [31:0] BASE = 32'h1c000000;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    rbeat_t rq[$];
    bexp_t bq[$];
    logic [31:0] wd[$];
    logic [31:0] model [int];
    int checks = 0;
    int errors = 0;
    int r_beats = 0;

    axi3_sram_slave_if bus();
    axi3_sram_slave_if bus4();

    axi3_sram_slave #(.ADDR_BITS(16), .BASE_ADDR(BASE), .READ_LAT(1)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    axi3_sram_slave #(.ADDR_BITS(16), .BASE_ADDR(BASE), .READ_LAT(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn), .bus(bus4)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void mwrite(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(off[15:2]);
        logic [31:0] w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[idx] = w;
    endfunction

    // R scoreboard: every valid beat, stalled or not, is compared with the queue head
    always @(negedge aclk)
        if (aresetn && bus.rvalid) begin
            if (rq.size() == 0) check("r_extra", bus.rvalid, 0);
            else begin
                check("rid", bus.rid, rq[0].id);
                check("rdata", bus.rdata, rq[0].data);
                check("rresp", bus.rresp, rq[0].resp);
                check("rlast", bus.rlast, rq[0].last);
                if (bus.rready) begin
                    void'(rq.pop_front());
                    r_beats++;
                end
            end
        end

    // B scoreboard
    always @(negedge aclk)
        if (aresetn && bus.bvalid) begin
            if (bq.size() == 0) check("b_extra", bus.bvalid, 0);
            else begin
                check("bid", bus.bid, bq[0].id);
                check("bresp", bus.bresp, bq[0].resp);
                if (bus.bready) void'(bq.pop_front());
            end
        end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arvalid = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0;
        bus.rready = 1; bus.bready = 1;
        bus4.arid = 0; bus4.araddr = 0; bus4.arlen = 0; bus4.arsize = 0; bus4.arburst = 0; bus4.arvalid = 0;
        bus4.awid = 0; bus4.awaddr = 0; bus4.awlen = 0; bus4.awsize = 0; bus4.awburst = 0; bus4.awvalid = 0;
        bus4.wid = 0; bus4.wdata = 0; bus4.wstrb = 0; bus4.wlast = 0; bus4.wvalid = 0;
        bus4.rready = 1; bus4.bready = 1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awvalid = 1;
        @(negedge aclk);
        for (int n = 0; n < 50 && !bus.awready; n++) @(negedge aclk);
        if (!bus.awready) check("aw_timeout", bus.awready, 1);
        @(posedge aclk); #1;
        bus.awvalid = 0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arvalid = 1;
        @(negedge aclk);
        for (int n = 0; n < 50 && !bus.arready; n++) @(negedge aclk);
        if (!bus.arready) check("ar_timeout", bus.arready, 1);
        @(posedge aclk); #1;
        bus.arvalid = 0;
    endtask

    task automatic w_send(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb, input logic last);
        bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1;
        @(negedge aclk);
        for (int n = 0; n < 50 && !bus.wready; n++) @(negedge aclk);
        if (!bus.wready) check("w_timeout", bus.wready, 1);
        @(posedge aclk); #1;
        bus.wvalid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (rq.size() != 0 || bq.size() != 0); n++) @(negedge aclk);
        if (rq.size() != 0) check("r_timeout", rq.size(), 0);
        if (bq.size() != 0) check("b_timeout", bq.size(), 0);
        rq.delete();
        bq.delete();
        @(posedge aclk); #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst,
                               input logic [3:0] strb, input logic [3:0] wid, input bit bad_last);
        int len = wd.size() - 1;
        logic [31:0] off = addr - BASE;
        bit dec = off >= 32'h10000;
        bit apply = !dec && wid == id && !burst[1];
        bexp_t e;
        e.id = id;
        e.resp = dec ? 2'b11 : (burst[1] || wid != id || bad_last) ? 2'b10 : 2'b00;
        bq.push_back(e);
        aw_send(id, addr, 8'(len), 3'd2, burst);
        for (int i = 0; i <= len; i++) begin
            w_send(wid, wd[i], strb, (i == len) ^ bad_last);
            if (apply) mwrite(off, wd[i], strb);
            if (burst == 2'b01) off = (off + 32'd4) & 32'hFFFF;
        end
        drain();
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] off = addr - BASE;
        bit dec = off >= 32'h10000;
        int n_beats = (len > 15 ? 15 : int'(len)) + 1;
        int beats0 = r_beats;
        int lat;
        rbeat_t e;
        for (int i = 0; i < n_beats; i++) begin
            e.id = id;
            e.data = dec ? 32'h0 : (model.exists(int'(off[15:2])) ? model[int'(off[15:2])] : 32'h0);
            e.resp = dec ? 2'b11 : (size > 2 || burst[1]) ? 2'b10 : 2'b00;
            e.last = i == n_beats - 1;
            rq.push_back(e);
            if (burst != 2'b00) off = (off + (32'd1 << size)) & 32'hFFFF;
        end
        ar_send(id, addr, len, size, burst);
        @(negedge aclk);
        lat = 1;
        while (!bus.rvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        check("r_lat", lat, 1);
        drain();
        check("r_count", r_beats - beats0, n_beats);
    endtask

    initial begin
        int lat;
        idle_bus();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rid", bus.rid, 0);
        check("rst_bid", bus.bid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_bresp", bus.bresp, 0);
        @(posedge aclk); #1;
        aresetn = 1;
        @(negedge aclk);
        check("rel_arready0", bus.arready, 0);
        @(negedge aclk);
        check("rel_arready1", bus.arready, 1);
        check("rel_awready1", bus.awready, 1);
        @(posedge aclk); #1;

        // basic INCR write then readback
        wd = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_burst(4'h3, BASE + 32'h100, 2'b01, 4'hF, 4'h3, 0);
        read_burst(4'h6, BASE + 32'h100, 8'd3, 3'd2, 2'b01);

        // byte strobe merge
        wd = '{32'h11223344};
        write_burst(4'h1, BASE + 32'h200, 2'b01, 4'hF, 4'h1, 0);
        wd = '{32'hAABBCCDD};
        write_burst(4'h1, BASE + 32'h200, 2'b01, 4'b0010, 4'h1, 0);
        read_burst(4'h2, BASE + 32'h200, 8'd0, 3'd2, 2'b01);

        // DECERR reads return zero, DECERR writes leave the aliased word alone
        wd = '{32'hCAFEF00D};
        write_burst(4'h2, BASE, 2'b01, 4'hF, 4'h2, 0);
        read_burst(4'h1, 32'h0, 8'd1, 3'd2, 2'b01);
        wd = '{32'hDEADBEEF};
        write_burst(4'h2, 32'h0, 2'b01, 4'hF, 4'h2, 0);
        read_burst(4'h1, BASE, 8'd0, 3'd2, 2'b01);

        // SLVERR size still returns array data and steps by 8 bytes; FIXED repeats one word
        read_burst(4'h4, BASE + 32'h100, 8'd1, 3'd3, 2'b01);
        read_burst(4'h5, BASE + 32'h104, 8'd2, 3'd2, 2'b00);

        // arlen above 15 is clipped to 16 beats
        wd.delete();
        for (int i = 0; i < 16; i++) wd.push_back(32'h5000 + 32'(i * 17));
        write_burst(4'h7, BASE + 32'h400, 2'b01, 4'hF, 4'h7, 0);
        read_burst(4'h7, BASE + 32'h400, 8'd40, 3'd2, 2'b01);

        // INCR burst wrapping from the top of the window back to BASE
        wd = '{32'hA1A1A1A1, 32'hA2A2A2A2};
        write_burst(4'h7, BASE + 32'hFFFC, 2'b01, 4'hF, 4'h7, 0);
        read_burst(4'h7, BASE + 32'hFFFC, 8'd1, 3'd2, 2'b01);
        read_burst(4'h7, BASE, 8'd0, 3'd2, 2'b01);

        // wid mismatch: SLVERR and no write; wlast misplaced: SLVERR but data lands
        wd = '{32'h55555555};
        write_burst(4'h8, BASE + 32'h100, 2'b01, 4'hF, 4'h9, 0);
        read_burst(4'h8, BASE + 32'h100, 8'd0, 3'd2, 2'b01);
        wd = '{32'h66, 32'h77};
        write_burst(4'hA, BASE + 32'h300, 2'b01, 4'hF, 4'hA, 1);
        read_burst(4'hA, BASE + 32'h300, 8'd1, 3'd2, 2'b01);

        // rready pattern 1,0,0,1 across a 3-beat burst
        fork
            read_burst(4'hB, BASE + 32'h100, 8'd2, 3'd2, 2'b01);
            begin
                for (int n = 0; n < 40 && !bus.rvalid; n++) @(negedge aclk);
                @(posedge aclk); #1;
                bus.rready = 0;
                @(posedge aclk);
                @(posedge aclk); #1;
                bus.rready = 1;
            end
        join

        // same-cycle read and write of one word: read sees the old value
        wd = '{32'h12345678};
        write_burst(4'h1, BASE + 32'h500, 2'b01, 4'hF, 4'h1, 0);
        bq.push_back(bexp_t'{4'h1, 2'b00});
        aw_send(4'h1, BASE + 32'h500, 8'd0, 3'd2, 2'b01);
        fork
            begin
                w_send(4'h1, 32'h9ABCDEF0, 4'hF, 1);
                mwrite(32'h500, 32'h9ABCDEF0, 4'hF);
            end
            read_burst(4'h2, BASE + 32'h500, 8'd0, 3'd2, 2'b01);
        join
        read_burst(4'h2, BASE + 32'h500, 8'd0, 3'd2, 2'b01);

        // reset mid write burst after two of four beats
        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        write_burst(4'h3, BASE + 32'h600, 2'b01, 4'hF, 4'h3, 0);
        aw_send(4'h3, BASE + 32'h600, 8'd3, 3'd2, 2'b01);
        w_send(4'h3, 32'hB0, 4'hF, 0);
        mwrite(32'h600, 32'hB0, 4'hF);
        w_send(4'h3, 32'hB1, 4'hF, 0);
        mwrite(32'h604, 32'hB1, 4'hF);
        aresetn = 0;
        @(negedge aclk);
        check("mid_rst_bvalid", bus.bvalid, 0);
        check("mid_rst_wready", bus.wready, 0);
        check("mid_rst_awready", bus.awready, 0);
        @(posedge aclk); #1;
        aresetn = 1;
        @(negedge aclk);
        @(negedge aclk);
        check("post_rst_awready", bus.awready, 1);
        check("post_rst_bvalid", bus.bvalid, 0);
        @(posedge aclk); #1;
        read_burst(4'h3, BASE + 32'h600, 8'd3, 3'd2, 2'b01);

        // READ_LAT=4 instance: first rvalid four edges after the AR handshake
        bus4.arid = 4'h5; bus4.araddr = 32'h00001000; bus4.arlen = 8'd1; bus4.arsize = 3'd2; bus4.arburst = 2'b01;
        bus4.arvalid = 1;
        @(negedge aclk);
        for (int n = 0; n < 50 && !bus4.arready; n++) @(negedge aclk);
        if (!bus4.arready) check("ar4_timeout", bus4.arready, 1);
        @(posedge aclk); #1;
        bus4.arvalid = 0;
        @(negedge aclk);
        lat = 1;
        while (!bus4.rvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        check("lat4", lat, 4);
        check("lat4_rid", bus4.rid, 4'h5);
        check("lat4_rresp", bus4.rresp, 2'b11);
        check("lat4_rdata", bus4.rdata, 0);
        check("lat4_rlast0", bus4.rlast, 0);
        @(negedge aclk);
        check("lat4_rvalid1", bus4.rvalid, 1);
        check("lat4_rlast1", bus4.rlast, 1);
        @(negedge aclk);
        check("lat4_done", bus4.rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
